// File: rtl/mips_defs.sv
// Shared MIPS ID-stage definitions: opcodes, control word layout and the bubble control word.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [7:0] NOP_CTRL_DEFAULT = 8'h00;

    localparam logic [7:0] CTRL_RTYPE  = 8'b1001_0010;
    localparam logic [7:0] CTRL_LW     = 8'b0111_1000;
    localparam logic [7:0] CTRL_SW     = 8'b0100_0100;
    localparam logic [7:0] CTRL_BRANCH = 8'b0000_0001;
    localparam logic [7:0] CTRL_ADDI   = 8'b0101_0000;

    // Field order matches the exCtrl bus, MSB first.
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
    } ctrl_t;

    // Opcodes whose rt field is a source operand (as opposed to a destination).
    function automatic logic op_reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/instruction_decode_reg_file.sv
// 32x32 register file: two async read ports with same-cycle write bypass, one sync write port.
module reg_file
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o
);

    logic [31:0] regs_q [32];
    logic        wr_valid;

    assign wr_valid = we_i && (waddr_i != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_valid) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = regs_q[raddr_a_i];
        rdata_b_o = regs_q[raddr_b_i];
        if (raddr_a_i == 5'd0) begin
            rdata_a_o = '0;
        end else if (wr_valid && (waddr_i == raddr_a_i)) begin
            rdata_a_o = wdata_i;
        end
        if (raddr_b_i == 5'd0) begin
            rdata_b_o = '0;
        end else if (wr_valid && (waddr_i == raddr_b_i)) begin
            rdata_b_o = wdata_i;
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// MIPS ID stage: control decode, register read, hazard detection, branch/jump resolution
// and the ID/EX pipeline register.
module instruction_decode
    import mips_defs::*;
#(
    parameter logic [7:0] NOP_CTRL = NOP_CTRL_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] ifIdReg,
    input  logic        wbEnable,
    input  logic [4:0]  wbAddr,
    input  logic [31:0] wbData,
    input  logic        memRegWrite,
    input  logic [4:0]  memRd,
    output logic        stall,
    output logic        branchTaken,
    output logic [31:0] branchAddrs,
    output logic [7:0]  exCtrl,
    output logic [31:0] exPc4,
    output logic [31:0] exRsData,
    output logic [31:0] exRtData,
    output logic [31:0] exImm,
    output logic [4:0]  exRs,
    output logic [4:0]  exRt,
    output logic [4:0]  exRd,
    output logic [5:0]  exFunct
);

    logic [31:0] instr, pc, pc4, imm_ext, br_target, j_target;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic        bubble_in, is_branch, is_jump;
    logic [31:0] rs_data, rt_data;
    ctrl_t       ctrl_dec;

    assign instr     = ifIdReg[63:32];
    assign pc        = ifIdReg[31:0];
    assign pc4       = pc + 32'd4;
    assign op        = instr[31:26];
    assign rs        = instr[25:21];
    assign rt        = instr[20:16];
    assign rd        = instr[15:11];
    assign imm_ext   = {{16{instr[15]}}, instr[15:0]};
    assign br_target = pc4 + {imm_ext[29:0], 2'b00};
    assign j_target  = {pc4[31:28], instr[25:0], 2'b00};
    assign bubble_in = (instr == 32'd0);
    assign is_branch = !bubble_in && ((op == OP_BEQ) || (op == OP_BNE));
    assign is_jump   = !bubble_in && (op == OP_J);

    reg_file u_reg_file (
        .clk       (clk),
        .reset     (reset),
        .we_i      (wbEnable),
        .waddr_i   (wbAddr),
        .wdata_i   (wbData),
        .raddr_a_i (rs),
        .raddr_b_i (rt),
        .rdata_a_o (rs_data),
        .rdata_b_o (rt_data)
    );

    always_comb begin
        ctrl_dec = NOP_CTRL;
        if (!bubble_in) begin
            case (op)
                OP_RTYPE:       ctrl_dec = CTRL_RTYPE;
                OP_LW:          ctrl_dec = CTRL_LW;
                OP_SW:          ctrl_dec = CTRL_SW;
                OP_BEQ, OP_BNE: ctrl_dec = CTRL_BRANCH;
                OP_ADDI:        ctrl_dec = CTRL_ADDI;
                default:        ctrl_dec = NOP_CTRL;
            endcase
        end
    end

    ctrl_t       ex_ctrl_q, ex_ctrl_d;
    logic [31:0] ex_pc4_q, ex_rs_data_q, ex_rt_data_q, ex_imm_q;
    logic [4:0]  ex_rs_q, ex_rt_q, ex_rd_q;
    logic [5:0]  ex_funct_q;

    logic [4:0] ex_dst;
    logic       load_use, rs_busy, rt_busy, br_hazard, br_cond;

    assign ex_dst = ex_ctrl_q.reg_dst ? ex_rd_q : ex_rt_q;

    // A branch compares in ID, so any pending write to its sources (EX or MEM) must drain first.
    always_comb begin
        load_use  = ex_ctrl_q.mem_read && (ex_rt_q != 5'd0) &&
                    ((ex_rt_q == rs) || ((ex_rt_q == rt) && !bubble_in && op_reads_rt(op)));
        rs_busy   = (rs != 5'd0) &&
                    ((ex_ctrl_q.reg_write && (ex_dst == rs)) || (memRegWrite && (memRd == rs)));
        rt_busy   = (rt != 5'd0) &&
                    ((ex_ctrl_q.reg_write && (ex_dst == rt)) || (memRegWrite && (memRd == rt)));
        br_hazard = is_branch && (rs_busy || rt_busy);
        br_cond   = (op == OP_BEQ) ? (rs_data == rt_data) : (rs_data != rt_data);
    end

    always_comb begin
        stall       = 1'b0;
        branchTaken = 1'b0;
        branchAddrs = '0;
        if (!reset) begin
            stall       = load_use || br_hazard;
            branchAddrs = pc4;
            if (!stall) begin
                if (is_jump) begin
                    branchTaken = 1'b1;
                    branchAddrs = j_target;
                end else if (is_branch && br_cond) begin
                    branchTaken = 1'b1;
                    branchAddrs = br_target;
                end
            end
        end
    end

    assign ex_ctrl_d = stall ? ctrl_t'(NOP_CTRL) : ctrl_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ctrl_q    <= '0;
            ex_pc4_q     <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            ex_funct_q   <= '0;
        end else begin
            ex_ctrl_q    <= ex_ctrl_d;
            ex_pc4_q     <= pc4;
            ex_rs_data_q <= rs_data;
            ex_rt_data_q <= rt_data;
            ex_imm_q     <= imm_ext;
            ex_rs_q      <= rs;
            ex_rt_q      <= rt;
            ex_rd_q      <= rd;
            ex_funct_q   <= instr[5:0];
        end
    end

    assign exCtrl   = ex_ctrl_q;
    assign exPc4    = ex_pc4_q;
    assign exRsData = ex_rs_data_q;
    assign exRtData = ex_rt_data_q;
    assign exImm    = ex_imm_q;
    assign exRs     = ex_rs_q;
    assign exRt     = ex_rt_q;
    assign exRd     = ex_rd_q;
    assign exFunct  = ex_funct_q;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode with hand-computed expectations.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] ifIdReg;
    logic        wbEnable;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        memRegWrite;
    logic [4:0]  memRd;
    logic        stall, branchTaken;
    logic [31:0] branchAddrs, exPc4, exRsData, exRtData, exImm;
    logic [7:0]  exCtrl;
    logic [4:0]  exRs, exRt, exRd;
    logic [5:0]  exFunct;

    int tests = 0;
    int fails = 0;

    instruction_decode dut (
        .clk         (clk),
        .reset       (reset),
        .ifIdReg     (ifIdReg),
        .wbEnable    (wbEnable),
        .wbAddr      (wbAddr),
        .wbData      (wbData),
        .memRegWrite (memRegWrite),
        .memRd       (memRd),
        .stall       (stall),
        .branchTaken (branchTaken),
        .branchAddrs (branchAddrs),
        .exCtrl      (exCtrl),
        .exPc4       (exPc4),
        .exRsData    (exRsData),
        .exRtData    (exRtData),
        .exImm       (exImm),
        .exRs        (exRs),
        .exRt        (exRt),
        .exRd        (exRd),
        .exFunct     (exFunct)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        reset       = 1'b1;
        ifIdReg     = '0;
        wbEnable    = 1'b0;
        wbAddr      = '0;
        wbData      = '0;
        memRegWrite = 1'b0;
        memRd       = '0;

        // Reset: j instruction present but outputs must stay forced low.
        tick(); tick();
        ifIdReg = {32'h0800_0100, 32'h1000_0000};
        #1;
        chk("rst_exCtrl",   exCtrl, 0);
        chk("rst_exPc4",    exPc4, 0);
        chk("rst_exRsData", exRsData, 0);
        chk("rst_stall",    stall, 0);
        chk("rst_taken",    branchTaken, 0);
        chk("rst_addrs",    branchAddrs, 0);

        // add $0,$5,$0 : read $5 after reset
        reset   = 1'b0;
        ifIdReg = {32'h00A0_0020, 32'h0000_0000};
        tick();
        chk("rd5_data",  exRsData, 0);
        chk("rd5_pc4",   exPc4, 32'h4);
        chk("rd5_ctrl",  exCtrl, 8'h92);
        chk("rd5_rs",    exRs, 5);

        // add $4,$3,$0 with simultaneous WB of $3
        ifIdReg  = {32'h0060_2020, 32'h0000_0008};
        wbEnable = 1'b1; wbAddr = 5'd3; wbData = 32'hDEAD_BEEF;
        #1;
        chk("byp_stall", stall, 0);
        tick();
        wbEnable = 1'b0;
        chk("byp_rsdata", exRsData, 32'hDEAD_BEEF);
        chk("byp_rtdata", exRtData, 0);
        chk("byp_rd",     exRd, 4);
        chk("byp_funct",  exFunct, 6'h20);
        tick();
        chk("wr3_stored", exRsData, 32'hDEAD_BEEF);

        // wbAddr = 0 write ignored
        ifIdReg  = {32'h0000_2020, 32'h0000_000C};
        wbEnable = 1'b1; wbAddr = 5'd0; wbData = 32'h1234_5678;
        tick();
        wbEnable = 1'b0;
        chk("r0_byp", exRsData, 0);
        tick();
        chk("r0_read", exRsData, 0);

        // lw $2,0($1) then add $5,$2,$2 : one-cycle load-use stall
        ifIdReg = {32'h8C22_0000, 32'h0000_0020};
        #1;
        chk("lu_nostall", stall, 0);
        tick();
        ifIdReg = {32'h0042_2820, 32'h0000_0024};
        #1;
        chk("lu_stall",  stall, 1);
        chk("lu_taken",  branchTaken, 0);
        chk("lu_exctrl", exCtrl, 8'h78);
        chk("lu_exrt",   exRt, 2);
        tick();
        chk("lu_bubble", exCtrl, 0);
        chk("lu_clear",  stall, 0);
        tick();
        chk("lu_add_ctrl", exCtrl, 8'h92);
        chk("lu_add_rd",   exRd, 5);
        chk("lu_add_pc4",  exPc4, 32'h28);

        // sw $7,-8($1)
        ifIdReg = {32'hAC27_FFF8, 32'h0000_0030};
        tick();
        chk("sw_ctrl", exCtrl, 8'h44);
        chk("sw_imm",  exImm, 32'hFFFF_FFF8);

        // beq $1,$1,+3 / bne $1,$1,+3 at 0x40
        ifIdReg = {32'h1021_0003, 32'h0000_0040};
        #1;
        chk("beq_taken", branchTaken, 1);
        chk("beq_addr",  branchAddrs, 32'h50);
        chk("beq_stall", stall, 0);
        ifIdReg = {32'h1421_0003, 32'h0000_0040};
        #1;
        chk("bne_taken", branchTaken, 0);
        chk("bne_addr",  branchAddrs, 32'h44);
        ifIdReg = {32'h1021_0003, 32'h0000_0040};
        tick();
        chk("beq_exctrl", exCtrl, 8'h01);

        // beq $0,$0,-1 at 0x100 : backward target
        ifIdReg = {32'h1000_FFFF, 32'h0000_0100};
        #1;
        chk("beqneg_addr", branchAddrs, 32'h100);

        // bne $3,$0,+2 at 0x80 : $3 = DEADBEEF, taken
        ifIdReg = {32'h1460_0002, 32'h0000_0080};
        #1;
        chk("bne3_taken", branchTaken, 1);
        chk("bne3_addr",  branchAddrs, 32'h8C);

        // j 0x100 at 0x1000_0000
        ifIdReg = {32'h0800_0100, 32'h1000_0000};
        #1;
        chk("j_taken", branchTaken, 1);
        chk("j_addr",  branchAddrs, 32'h1000_0400);
        tick();
        chk("j_exctrl", exCtrl, 0);

        // addi $6,$0,1 then beq $6,$0,+5 : EX then MEM hazard, then not taken
        ifIdReg = {32'h2006_0001, 32'h0000_0200};
        tick();
        chk("addi_ctrl", exCtrl, 8'h50);
        chk("addi_imm",  exImm, 1);
        ifIdReg = {32'h10C0_0005, 32'h0000_0204};
        #1;
        chk("bh1_stall", stall, 1);
        chk("bh1_taken", branchTaken, 0);
        tick();
        memRegWrite = 1'b1; memRd = 5'd6;
        #1;
        chk("bh2_bubble", exCtrl, 0);
        chk("bh2_stall",  stall, 1);
        chk("bh2_taken",  branchTaken, 0);
        tick();
        memRegWrite = 1'b0;
        wbEnable = 1'b1; wbAddr = 5'd6; wbData = 32'h1;
        #1;
        chk("bh3_stall", stall, 0);
        chk("bh3_taken", branchTaken, 0);
        chk("bh3_addr",  branchAddrs, 32'h208);
        tick();
        wbEnable = 1'b0;
        chk("bh3_exctrl", exCtrl, 8'h01);

        // Mid-operation reset clears ID/EX and the register file
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        chk("mrst_exctrl", exCtrl, 0);
        ifIdReg = {32'h0060_2020, 32'h0000_0300};
        tick();
        chk("mrst_r3", exRsData, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
